// File: rtl/dac_serializer_stereo_if.sv
`default_nettype none
// ============================================================================
// Interface : dac_serializer_stereo_if
// Brief     : Valid/ready stereo sample-pair stream into the DAC serialiser.
// Revision  : 1.0 - initial release
// ============================================================================
interface dac_serializer_stereo_if #(
    parameter int DATA_W = 16
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_left;
    logic [DATA_W-1:0] s_right;

    modport master (
        output s_valid,
        output s_left,
        output s_right,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_left,
        input  s_right,
        output s_ready
    );
endinterface
`default_nettype wire

// File: rtl/dac_serializer_stereo.sv
`default_nettype none
// ============================================================================
// Module   : dac_serializer_stereo
// Brief    : Stereo sample FIFO feeding a left-justified / I2S DAC serialiser
//            that oversamples the codec bit and frame clocks on CLOCK_50.
// Revision : 1.0 - initial release
// ============================================================================
module dac_serializer_stereo #(
    parameter int DATA_W      = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int MODE        = 0,
    parameter int SYNC_STAGES = 3
) (
    input  logic                               CLOCK_50,
    input  logic                               resetn,
    input  logic                               AUD_BCLK,
    input  logic                               AUD_DACLRCK,
    dac_serializer_stereo_if.slave             s_if,
    input  logic                               mute,
    output logic                               AUD_DACDAT,
    output logic                               underrun,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

    localparam int c_lvl_w = $clog2(FIFO_DEPTH + 1);
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = $clog2(DATA_W + 1);
    localparam logic [c_lvl_w-1:0] c_full     = c_lvl_w'(FIFO_DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(DATA_W);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_SHIFT = 2'd2,
        ST_PAD   = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_bclk_sync;
    logic [SYNC_STAGES-1:0] r_lrck_sync;
    logic                   r_bclk_d;
    logic                   r_lrck_q;
    logic                   w_bclk_fall;
    logic                   w_lrck;
    logic                   w_slot_start;
    logic                   w_left_start;
    logic                   w_right_start;

    logic [2*DATA_W-1:0]    r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]     r_wr_ptr;
    logic [c_ptr_w-1:0]     r_rd_ptr;
    logic [c_lvl_w-1:0]     r_level;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_empty;
    logic [2*DATA_W-1:0]    w_head;
    logic [DATA_W-1:0]      w_frame_l;
    logic [DATA_W-1:0]      w_frame_r;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [DATA_W-1:0]      r_sreg;
    logic [DATA_W-1:0]      w_sreg_nxt;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [c_cnt_w-1:0]     w_cnt_nxt;
    logic [DATA_W-1:0]      r_shadow_r;
    logic                   w_bit_nxt;
    logic                   w_load_en;
    logic [DATA_W-1:0]      w_load_data;
    logic                   r_dacdat;
    logic                   r_underrun;

    assign w_bclk_fall   = r_bclk_d & ~r_bclk_sync[SYNC_STAGES-1];
    assign w_lrck        = r_lrck_sync[SYNC_STAGES-1];
    assign w_slot_start  = w_bclk_fall & (w_lrck != r_lrck_q);
    assign w_left_start  = w_slot_start & w_lrck;
    assign w_right_start = w_slot_start & ~w_lrck;

    // lrck_q resets to "left" so output only resumes on a genuine 0->1 edge,
    // never part-way through a left slot that was in progress at reset.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_bclk_sync <= '0;
            r_lrck_sync <= '0;
            r_bclk_d    <= 1'b0;
            r_lrck_q    <= 1'b1;
        end else begin
            r_bclk_sync <= {r_bclk_sync[SYNC_STAGES-2:0], AUD_BCLK};
            r_lrck_sync <= {r_lrck_sync[SYNC_STAGES-2:0], AUD_DACLRCK};
            r_bclk_d    <= r_bclk_sync[SYNC_STAGES-1];
            if (w_slot_start) begin
                r_lrck_q <= w_lrck;
            end
        end
    end

    assign s_if.s_ready = (r_level != c_full);
    assign w_push       = s_if.s_valid & s_if.s_ready;
    assign w_empty      = (r_level == '0);
    assign w_pop        = w_left_start & ~w_empty;
    assign w_head       = r_mem[r_rd_ptr];
    assign w_frame_l    = w_empty ? '0 : w_head[2*DATA_W-1:DATA_W];
    assign w_frame_r    = w_empty ? '0 : w_head[DATA_W-1:0];
    assign fifo_level   = r_level;

    always_ff @(posedge CLOCK_50) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {s_if.s_left, s_if.s_right};
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_lvl_w'(1);
                2'b01:   r_level <= r_level - c_lvl_w'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // A slot start always wins over an unfinished shift: short slots truncate.
    always_comb begin
        w_state_nxt = r_state;
        w_sreg_nxt  = r_sreg;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = 1'b0;
        w_load_en   = 1'b0;
        w_load_data = '0;
        if (w_left_start) begin
            w_load_en   = 1'b1;
            w_load_data = w_frame_l;
        end else if (w_right_start && (r_state != ST_IDLE)) begin
            w_load_en   = 1'b1;
            w_load_data = r_shadow_r;
        end
        if (w_load_en) begin
            if (MODE == 1) begin
                w_state_nxt = ST_DELAY;
                w_sreg_nxt  = w_load_data;
                w_cnt_nxt   = '0;
            end else begin
                w_state_nxt = ST_SHIFT;
                w_bit_nxt   = w_load_data[DATA_W-1];
                w_sreg_nxt  = {w_load_data[DATA_W-2:0], 1'b0};
                w_cnt_nxt   = c_cnt_w'(1);
            end
        end else begin
            case (r_state)
                ST_DELAY, ST_SHIFT: begin
                    w_bit_nxt   = r_sreg[DATA_W-1];
                    w_sreg_nxt  = {r_sreg[DATA_W-2:0], 1'b0};
                    w_cnt_nxt   = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + c_cnt_w'(1);
                    w_state_nxt = (r_cnt == c_cnt_last) ? ST_PAD : ST_SHIFT;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_sreg     <= '0;
            r_cnt      <= '0;
            r_shadow_r <= '0;
            r_dacdat   <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= w_left_start & w_empty;
            if (w_left_start) begin
                r_shadow_r <= w_frame_r;
            end
            if (w_bclk_fall) begin
                r_state  <= w_state_nxt;
                r_sreg   <= w_sreg_nxt;
                r_cnt    <= w_cnt_nxt;
                r_dacdat <= w_bit_nxt & ~mute;
            end
        end
    end

    assign AUD_DACDAT = r_dacdat;
    assign underrun   = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_dac_serializer_stereo.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_serializer_stereo
// Brief    : Directed self-checking bench: 16-bit LJ, 16-bit I2S, 24-bit LJ.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dac_serializer_stereo;

    logic        CLOCK_50    = 1'b0;
    logic        resetn      = 1'b0;
    logic        AUD_BCLK    = 1'b1;
    logic        AUD_DACLRCK = 1'b0;
    logic        mute        = 1'b0;
    logic        dacdat_a, dacdat_b, dacdat_c;
    logic        underrun_a, underrun_b, underrun_c;
    logic [2:0]  level_a, level_b, level_c;
    logic [63:0] cap_a, cap_b, cap_c;
    int          checks   = 0;
    int          failures = 0;
    int          urun_a   = 0;

    dac_serializer_stereo_if #(.DATA_W(16)) if_a ();
    dac_serializer_stereo_if #(.DATA_W(16)) if_b ();
    dac_serializer_stereo_if #(.DATA_W(24)) if_c ();

    dac_serializer_stereo #(.DATA_W(16), .FIFO_DEPTH(4), .MODE(0), .SYNC_STAGES(3)) u_dut_a (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .AUD_BCLK(AUD_BCLK), .AUD_DACLRCK(AUD_DACLRCK),
        .s_if(if_a), .mute(mute), .AUD_DACDAT(dacdat_a), .underrun(underrun_a), .fifo_level(level_a)
    );
    dac_serializer_stereo #(.DATA_W(16), .FIFO_DEPTH(4), .MODE(1), .SYNC_STAGES(3)) u_dut_b (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .AUD_BCLK(AUD_BCLK), .AUD_DACLRCK(AUD_DACLRCK),
        .s_if(if_b), .mute(mute), .AUD_DACDAT(dacdat_b), .underrun(underrun_b), .fifo_level(level_b)
    );
    dac_serializer_stereo #(.DATA_W(24), .FIFO_DEPTH(4), .MODE(0), .SYNC_STAGES(3)) u_dut_c (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .AUD_BCLK(AUD_BCLK), .AUD_DACLRCK(AUD_DACLRCK),
        .s_if(if_c), .mute(mute), .AUD_DACDAT(dacdat_c), .underrun(underrun_c), .fifo_level(level_c)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Counts CLOCK_50 cycles with underrun high, so a stretched pulse shows up too.
    always @(posedge CLOCK_50) begin
        if (underrun_a === 1'b1) urun_a <= urun_a + 1;
    end

    // BCLK = CLOCK_50/16; the codec-side sample is taken on the BCLK rising edge.
    task automatic bclk_run(input int n, input logic lr);
        @(negedge CLOCK_50);
        for (int i = 0; i < n; i++) begin
            AUD_BCLK = 1'b0;
            if (i == 0) AUD_DACLRCK = lr;
            #80;
            AUD_BCLK = 1'b1;
            cap_a = {cap_a[62:0], dacdat_a};
            cap_b = {cap_b[62:0], dacdat_b};
            cap_c = {cap_c[62:0], dacdat_c};
            #80;
        end
    endtask

    task automatic do_frame(input int slot);
        cap_a = '0;
        cap_b = '0;
        cap_c = '0;
        bclk_run(slot, 1'b1);
        bclk_run(slot, 1'b0);
    endtask

    task automatic push16(input logic en_a, input logic en_b, input logic [15:0] l, input logic [15:0] r);
        @(negedge CLOCK_50);
        if_a.s_valid = en_a; if_a.s_left = l; if_a.s_right = r;
        if_b.s_valid = en_b; if_b.s_left = l; if_b.s_right = r;
        @(negedge CLOCK_50);
        if_a.s_valid = 1'b0;
        if_b.s_valid = 1'b0;
    endtask

    task automatic push24(input logic [23:0] l, input logic [23:0] r);
        @(negedge CLOCK_50);
        if_c.s_valid = 1'b1; if_c.s_left = l; if_c.s_right = r;
        @(negedge CLOCK_50);
        if_c.s_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        checks++; if (dacdat_a !== 1'b0) begin failures++; $display("FAIL reset_dacdat got=%b exp=0", dacdat_a); end
        checks++; if (underrun_a !== 1'b0) begin failures++; $display("FAIL reset_underrun got=%b exp=0", underrun_a); end
        checks++; if (level_a !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level_a); end
        checks++; if (if_a.s_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", if_a.s_ready); end
        resetn = 1'b1;
        bclk_run(4, 1'b0);
        checks++; if (dacdat_a !== 1'b0) begin failures++; $display("FAIL idle_dacdat got=%b exp=0", dacdat_a); end
    endtask

    task automatic test_frame_formats();
        logic [63:0] exp_a, exp_b, exp_c;
        int u0;
        exp_a = {16'hA5C3, 16'h0000, 16'h0FF0, 16'h0000};
        exp_b = {1'b0, 16'hA5C3, 15'h0, 1'b0, 16'h0FF0, 15'h0};
        exp_c = {24'hA5C35A, 8'h00, 24'h0FF0E1, 8'h00};
        push16(1'b1, 1'b1, 16'hA5C3, 16'h0FF0);
        push24(24'hA5C35A, 24'h0FF0E1);
        u0 = urun_a;
        do_frame(32);
        checks++; if (cap_a !== exp_a) begin failures++; $display("FAIL lj_frame got=%h exp=%h", cap_a, exp_a); end
        checks++; if (cap_b !== exp_b) begin failures++; $display("FAIL i2s_frame got=%h exp=%h", cap_b, exp_b); end
        checks++; if (cap_c !== exp_c) begin failures++; $display("FAIL w24_frame got=%h exp=%h", cap_c, exp_c); end
        checks++; if (urun_a - u0 !== 0) begin failures++; $display("FAIL lj_no_underrun got=%0d exp=0", urun_a - u0); end
    endtask

    task automatic test_fifo_full();
        push16(1'b1, 1'b0, 16'h1234, 16'hFEDC);
        push16(1'b1, 1'b0, 16'h8001, 16'h7FFE);
        push16(1'b1, 1'b0, 16'hFFFF, 16'h0000);
        push16(1'b1, 1'b0, 16'h0F0F, 16'hC0DE);
        checks++; if (level_a !== 3'd4) begin failures++; $display("FAIL full_level got=%0d exp=4", level_a); end
        checks++; if (if_a.s_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", if_a.s_ready); end
        if_a.s_valid = 1'b1; if_a.s_left = 16'hDEAD; if_a.s_right = 16'hBEEF;
        repeat (4) @(negedge CLOCK_50);
        checks++; if (level_a !== 3'd4) begin failures++; $display("FAIL held_level got=%0d exp=4", level_a); end
        checks++; if (if_a.s_ready !== 1'b0) begin failures++; $display("FAIL held_ready got=%b exp=0", if_a.s_ready); end
        if_a.s_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] pl [4];
        logic [15:0] pr [4];
        logic [63:0] exp;
        logic [2:0]  exp_lvl;
        int u0;
        pl = '{16'h1234, 16'h8001, 16'hFFFF, 16'h0F0F};
        pr = '{16'hFEDC, 16'h7FFE, 16'h0000, 16'hC0DE};
        u0 = urun_a;
        for (int f = 0; f < 5; f++) begin
            do_frame(32);
            exp     = (f < 4) ? {pl[f], 16'h0000, pr[f], 16'h0000} : 64'h0;
            exp_lvl = (f < 4) ? 3'(3 - f) : 3'd0;
            checks++; if (cap_a !== exp) begin failures++; $display("FAIL b2b_frame%0d got=%h exp=%h", f, cap_a, exp); end
            checks++; if (level_a !== exp_lvl) begin failures++; $display("FAIL b2b_level%0d got=%0d exp=%0d", f, level_a, exp_lvl); end
        end
        checks++; if (urun_a - u0 !== 1) begin failures++; $display("FAIL b2b_underrun_cycles got=%0d exp=1", urun_a - u0); end
    endtask

    task automatic test_mute();
        logic [63:0] exp;
        int u0;
        push16(1'b1, 1'b0, 16'h1111, 16'h2222);
        push16(1'b1, 1'b0, 16'h3C3C, 16'hC3C3);
        push16(1'b1, 1'b0, 16'h5A5A, 16'hA5A5);
        u0 = urun_a;
        do_frame(32);
        exp = {16'h1111, 16'h0000, 16'h2222, 16'h0000};
        checks++; if (cap_a !== exp) begin failures++; $display("FAIL mute_f1 got=%h exp=%h", cap_a, exp); end
        checks++; if (level_a !== 3'd2) begin failures++; $display("FAIL mute_lvl1 got=%0d exp=2", level_a); end
        mute = 1'b1;
        do_frame(32);
        mute = 1'b0;
        checks++; if (cap_a !== 64'h0) begin failures++; $display("FAIL mute_f2 got=%h exp=0", cap_a); end
        checks++; if (level_a !== 3'd1) begin failures++; $display("FAIL mute_lvl2 got=%0d exp=1", level_a); end
        do_frame(32);
        exp = {16'h5A5A, 16'h0000, 16'hA5A5, 16'h0000};
        checks++; if (cap_a !== exp) begin failures++; $display("FAIL mute_f3 got=%h exp=%h", cap_a, exp); end
        checks++; if (level_a !== 3'd0) begin failures++; $display("FAIL mute_lvl3 got=%0d exp=0", level_a); end
        checks++; if (urun_a - u0 !== 0) begin failures++; $display("FAIL mute_underrun got=%0d exp=0", urun_a - u0); end
    endtask

    task automatic test_short_slot();
        push24(24'hC3A55A, 24'h3C0FF1);
        push24(24'h81FF7E, 24'hE70018);
        do_frame(16);
        checks++; if (cap_c[31:0] !== {16'hC3A5, 16'h3C0F}) begin failures++; $display("FAIL short_f1 got=%h exp=c3a53c0f", cap_c[31:0]); end
        do_frame(16);
        checks++; if (cap_c[31:0] !== {16'h81FF, 16'hE700}) begin failures++; $display("FAIL short_f2 got=%h exp=81ffe700", cap_c[31:0]); end
    endtask

    task automatic test_reset_mid_slot();
        logic [63:0] exp;
        int u0;
        push16(1'b1, 1'b0, 16'hA5C3, 16'h0FF0);
        push16(1'b1, 1'b0, 16'h1357, 16'h2468);
        cap_a = '0;
        bclk_run(8, 1'b1);
        checks++; if (cap_a[7:0] !== 8'hA5) begin failures++; $display("FAIL pre_reset_bits got=%h exp=a5", cap_a[7:0]); end
        @(negedge CLOCK_50);
        resetn = 1'b0;
        #1;
        checks++; if (dacdat_a !== 1'b0) begin failures++; $display("FAIL async_reset_dacdat got=%b exp=0", dacdat_a); end
        checks++; if (level_a !== 3'd0) begin failures++; $display("FAIL async_reset_level got=%0d exp=0", level_a); end
        repeat (2) @(negedge CLOCK_50);
        resetn = 1'b1;
        cap_a = '0;
        bclk_run(24, 1'b1);
        bclk_run(32, 1'b0);
        checks++; if (cap_a !== 64'h0) begin failures++; $display("FAIL post_reset_quiet got=%h exp=0", cap_a); end
        u0 = urun_a;
        do_frame(32);
        checks++; if (cap_a !== 64'h0) begin failures++; $display("FAIL post_reset_empty got=%h exp=0", cap_a); end
        checks++; if (urun_a - u0 !== 1) begin failures++; $display("FAIL post_reset_underrun got=%0d exp=1", urun_a - u0); end
        push16(1'b1, 1'b0, 16'hBEEF, 16'h0123);
        do_frame(32);
        exp = {16'hBEEF, 16'h0000, 16'h0123, 16'h0000};
        checks++; if (cap_a !== exp) begin failures++; $display("FAIL post_reset_resume got=%h exp=%h", cap_a, exp); end
    endtask

    initial begin
        if_a.s_valid = 1'b0; if_a.s_left = '0; if_a.s_right = '0;
        if_b.s_valid = 1'b0; if_b.s_left = '0; if_b.s_right = '0;
        if_c.s_valid = 1'b0; if_c.s_left = '0; if_c.s_right = '0;
        test_reset();
        test_frame_formats();
        test_fifo_full();
        test_back_to_back();
        test_mute();
        test_short_slot();
        test_reset_mid_slot();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
